// File: rtl/uart_rx_fifo_1318_if.sv
// Byte-stream and host-read signals between the UART receiver, the receive FIFO and the host.
// The receiver/host side uses the master modport; the FIFO uses the slave modport.
interface uart_rx_fifo_1318_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
);
  logic                  Ok_Data_Rx;
  logic [WIDTH-1:0]      Rx_Data_In;
  logic                  Rd_En;
  logic                  Clr_Ovf;
  logic [WIDTH-1:0]      Rd_Data;
  logic                  Rd_Valid;
  logic                  Empty;
  logic                  Full;
  logic [DEPTH_LOG2:0]   Count;
  logic                  Overflow;

  modport master (
    output Ok_Data_Rx, Rx_Data_In, Rd_En, Clr_Ovf,
    input  Rd_Data, Rd_Valid, Empty, Full, Count, Overflow
  );

  modport slave (
    input  Ok_Data_Rx, Rx_Data_In, Rd_En, Clr_Ovf,
    output Rd_Data, Rd_Valid, Empty, Full, Count, Overflow
  );
endinterface

// File: rtl/uart_rx_fifo_1318.sv
// Receive-side circular FIFO: captures one byte per rising edge of Ok_Data_Rx and
// hands bytes to the host through a registered read port with fill-level status.
module uart_rx_fifo_1318 #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input logic                Clk_RX,
  input logic                Reset_R,
  uart_rx_fifo_1318_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  ok_d;
  logic                  overflow;
  logic                  rd_valid;
  logic [WIDTH-1:0]      rd_data;

  logic empty;
  logic full;
  logic wr_stb;
  logic rd_go;
  logic wr_acc;
  logic wr_drop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign wr_stb  = bus.Ok_Data_Rx & ~ok_d;
  assign rd_go   = bus.Rd_En & ~empty;
  // A read on the same edge frees the slot, so a write at full is still accepted.
  assign wr_acc  = wr_stb & (~full | rd_go);
  assign wr_drop = wr_stb & full & ~rd_go;

  // NOTE: storage has no reset so it maps onto plain RAM; only pointers and count define validity.
  always_ff @(posedge Clk_RX) begin
    if (wr_acc) mem[wr_ptr] <= bus.Rx_Data_In;
  end

  // ok_d resets high so a byte-ready level already present at reset release is ignored.
  // NOTE: all sequential state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge Clk_RX or negedge Reset_R) begin
    if (!Reset_R) begin
      ok_d     <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      ok_d     <= bus.Ok_Data_Rx;
      rd_valid <= rd_go;

      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;

      if (rd_go) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end

      case ({wr_acc, rd_go})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      // Setting on a dropped byte takes priority over a simultaneous clear.
      if (wr_drop)          overflow <= 1'b1;
      else if (bus.Clr_Ovf) overflow <= 1'b0;
    end
  end

  assign bus.Rd_Data  = rd_data;
  assign bus.Rd_Valid = rd_valid;
  assign bus.Empty    = empty;
  assign bus.Full     = full;
  assign bus.Count    = count;
  assign bus.Overflow = overflow;
endmodule

// File: tb/tb_uart_rx_fifo_1318.sv
// Directed bench for uart_rx_fifo_1318: ordering, edge-triggered capture, overflow,
// simultaneous read/write at full and empty, pointer wrap and asynchronous reset.
module tb_uart_rx_fifo_1318;
  logic Clk_RX = 1'b0;
  logic Reset_R;
  int   checks   = 0;
  int   failures = 0;

  uart_rx_fifo_1318_if #(.DEPTH_LOG2(4), .WIDTH(8)) bus ();

  uart_rx_fifo_1318 #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
    .Clk_RX  (Clk_RX),
    .Reset_R (Reset_R),
    .bus     (bus)
  );

  always #5 Clk_RX = ~Clk_RX;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte-ready pulse: high for one clock, then low for one clock.
  task automatic wr(input logic [7:0] b);
    @(negedge Clk_RX);
    bus.Ok_Data_Rx = 1'b1;
    bus.Rx_Data_In = b;
    @(negedge Clk_RX);
    bus.Ok_Data_Rx = 1'b0;
  endtask

  // Single-cycle read request; Rd_Valid must be low before and high one clock later.
  task automatic rd(input string tag, input logic [7:0] exp);
    @(negedge Clk_RX);
    check({tag, "_valid_pre"}, 32'(bus.Rd_Valid), 32'd0);
    bus.Rd_En = 1'b1;
    @(negedge Clk_RX);
    bus.Rd_En = 1'b0;
    check({tag, "_valid"}, 32'(bus.Rd_Valid), 32'd1);
    check({tag, "_data"}, 32'(bus.Rd_Data), 32'(exp));
  endtask

  initial begin
    logic [7:0] b;
    bus.Ok_Data_Rx = 1'b0;
    bus.Rx_Data_In = '0;
    bus.Rd_En      = 1'b0;
    bus.Clr_Ovf    = 1'b0;
    Reset_R        = 1'b0;
    #2;
    check("rst_count", 32'(bus.Count), 32'd0);
    check("rst_empty", 32'(bus.Empty), 32'd1);
    check("rst_full", 32'(bus.Full), 32'd0);
    check("rst_ovf", 32'(bus.Overflow), 32'd0);
    check("rst_valid", 32'(bus.Rd_Valid), 32'd0);
    check("rst_data", 32'(bus.Rd_Data), 32'd0);
    @(negedge Clk_RX);
    Reset_R = 1'b1;

    // 1: three bytes in, three bytes out in order
    wr(8'h11); wr(8'h22); wr(8'h33);
    check("t1_count3", 32'(bus.Count), 32'd3);
    check("t1_empty0", 32'(bus.Empty), 32'd0);
    rd("t1_rd0", 8'h11);
    rd("t1_rd1", 8'h22);
    rd("t1_rd2", 8'h33);
    @(negedge Clk_RX);
    check("t1_valid_drop", 32'(bus.Rd_Valid), 32'd0);
    check("t1_empty1", 32'(bus.Empty), 32'd1);
    check("t1_count0", 32'(bus.Count), 32'd0);

    // 2: long byte-ready level stores exactly one byte
    @(negedge Clk_RX);
    bus.Ok_Data_Rx = 1'b1;
    bus.Rx_Data_In = 8'hA5;
    repeat (10) @(negedge Clk_RX);
    bus.Ok_Data_Rx = 1'b0;
    check("t2_count1", 32'(bus.Count), 32'd1);
    rd("t2_rd", 8'hA5);

    // 3: overflow on the 17th byte, set beats clear, then clear alone
    for (int i = 0; i <= 16; i++) wr(8'(i));
    check("t3_full", 32'(bus.Full), 32'd1);
    check("t3_count16", 32'(bus.Count), 32'd16);
    check("t3_ovf", 32'(bus.Overflow), 32'd1);
    @(negedge Clk_RX);
    bus.Ok_Data_Rx = 1'b1;
    bus.Rx_Data_In = 8'h77;
    bus.Clr_Ovf    = 1'b1;
    @(negedge Clk_RX);
    bus.Ok_Data_Rx = 1'b0;
    bus.Clr_Ovf    = 1'b0;
    check("t3_set_wins", 32'(bus.Overflow), 32'd1);
    check("t3_count_hold", 32'(bus.Count), 32'd16);
    @(negedge Clk_RX);
    bus.Clr_Ovf = 1'b1;
    @(negedge Clk_RX);
    bus.Clr_Ovf = 1'b0;
    check("t3_ovf_clr", 32'(bus.Overflow), 32'd0);
    for (int i = 0; i < 16; i++) rd($sformatf("t3_rd%0d", i), 8'(i));
    check("t3_empty", 32'(bus.Empty), 32'd1);

    // 4: write and read on the same edge while full
    for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i));
    check("t4_full", 32'(bus.Full), 32'd1);
    @(negedge Clk_RX);
    bus.Ok_Data_Rx = 1'b1;
    bus.Rx_Data_In = 8'h5A;
    bus.Rd_En      = 1'b1;
    @(negedge Clk_RX);
    bus.Ok_Data_Rx = 1'b0;
    bus.Rd_En      = 1'b0;
    check("t4_valid", 32'(bus.Rd_Valid), 32'd1);
    check("t4_oldest", 32'(bus.Rd_Data), 32'h80);
    check("t4_count16", 32'(bus.Count), 32'd16);
    check("t4_ovf0", 32'(bus.Overflow), 32'd0);
    for (int i = 1; i < 16; i++) rd($sformatf("t4_rd%0d", i), 8'h80 + 8'(i));
    rd("t4_last", 8'h5A);
    check("t4_empty", 32'(bus.Empty), 32'd1);

    // Empty + write + read request: no fall-through
    @(negedge Clk_RX);
    bus.Ok_Data_Rx = 1'b1;
    bus.Rx_Data_In = 8'hC3;
    bus.Rd_En      = 1'b1;
    @(negedge Clk_RX);
    bus.Ok_Data_Rx = 1'b0;
    bus.Rd_En      = 1'b0;
    check("ft_valid0", 32'(bus.Rd_Valid), 32'd0);
    check("ft_hold_data", 32'(bus.Rd_Data), 32'h5A);
    check("ft_count1", 32'(bus.Count), 32'd1);
    rd("ft_rd", 8'hC3);

    // 5: 40 interleaved bytes across pointer wrap, plus reads while empty
    for (int i = 0; i < 40; i++) begin
      b = 8'(i * 7 + 3);
      wr(b);
      rd($sformatf("t5_rd%0d", i), b);
    end
    @(negedge Clk_RX);
    bus.Rd_En = 1'b1;
    repeat (2) @(negedge Clk_RX);
    bus.Rd_En = 1'b0;
    check("t5_empty_rd_valid", 32'(bus.Rd_Valid), 32'd0);
    check("t5_empty_rd_data", 32'(bus.Rd_Data), 32'(8'(39 * 7 + 3)));
    check("t5_count0", 32'(bus.Count), 32'd0);

    // 6: asynchronous reset mid-stream with Rd_Valid high, then release with byte-ready high
    for (int i = 0; i < 6; i++) wr(8'hE0 + 8'(i));
    @(negedge Clk_RX);
    bus.Rd_En = 1'b1;
    @(negedge Clk_RX);
    bus.Rd_En = 1'b0;
    check("t6_count5", 32'(bus.Count), 32'd5);
    check("t6_valid_pre", 32'(bus.Rd_Valid), 32'd1);
    #2;
    Reset_R = 1'b0;
    #1;
    check("t6_count0", 32'(bus.Count), 32'd0);
    check("t6_empty", 32'(bus.Empty), 32'd1);
    check("t6_valid0", 32'(bus.Rd_Valid), 32'd0);
    check("t6_data0", 32'(bus.Rd_Data), 32'd0);
    bus.Ok_Data_Rx = 1'b1;
    bus.Rx_Data_In = 8'h99;
    @(negedge Clk_RX);
    Reset_R = 1'b1;
    repeat (3) @(negedge Clk_RX);
    check("t6_no_capture", 32'(bus.Count), 32'd0);
    bus.Ok_Data_Rx = 1'b0;
    wr(8'h42);
    check("t6_post_count", 32'(bus.Count), 32'd1);
    rd("t6_post_rd", 8'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
